lcd_timing_ctrl: RTL
====================

// Module: lcd_timing_ctrl
// PURPOSE
//  Dot/line timing generator for the LCD pipeline. Counts dots and lines at one dot per clk.
//  Drives the PPU mode (STAT[1:0]) and LY.
//  Issues the one-cycle drawline strobe consumed by the line renderer, plus the VBlank and STAT interrupt strobes.
//  Sits directly upstream of the renderer. Gated by LCDC bit 7.
// PARAMETERS
//  DOTS_PER_LINE  456  dots per scanline, including HBlank
//  OAM_DOTS       80   mode-2 (OAM search) length in dots
//  XFER_DOTS      172  mode-3 (pixel transfer) length in dots
//  VISIBLE_LINES  144  lines 0..143 are visible; 144..TOTAL_LINES-1 are VBlank
//  TOTAL_LINES    154  lines per frame
// PORTS
//  clk            in   1  system clock; 1 dot per cycle
//  reset          in   1  synchronous, active-low reset
//  lcd_en         in   1  LCDC[7]; 0 holds timing idle
//  lyc            in   8  LYC register value
//  stat_sel       in   4  STAT[6:3] source enables {lyc,mode2,mode1,mode0}
//  drawline       out  1  one-cycle strobe: render line ly to the renderer
//  mode           out  2  0 HBlank, 1 VBlank, 2 OAM, 3 transfer
//  ly             out  8  current line, 0..TOTAL_LINES-1
//  lyc_match      out  1  STAT[2]: ly == lyc
//  vblank_irq     out  1  one-cycle strobe at VBlank entry
//  stat_irq       out  1  one-cycle strobe of the LCD STAT interrupt
//  frame_start    out  1  one-cycle strobe at line 0, dot 0
// BEHAVIOUR
//  - All outputs are flop outputs; none is decoded combinationally from inputs.
//  - Reset (reset==0 at clk edge): dot=0, ly=0, mode=0, all strobes 0, lyc_match=0. Takes effect mid-frame with no strobe emitted.
//  - Disabled (lcd_en==0): same values as reset, held every cycle; lyc_match still tracks (0==lyc).
//  - Enabled: dot increments by 1 each cycle; wraps DOTS_PER_LINE-1 -> 0.
//    At that wrap ly increments; ly wraps TOTAL_LINES-1 -> 0.
//  - First enabled cycle after lcd_en 0->1 has dot=0, ly=0, mode=2, frame_start=1.
//  - Mode for visible lines (ly<VISIBLE_LINES), per dot range:
//      dot <  OAM_DOTS           -> mode 2
//      dot <  OAM_DOTS+XFER_DOTS -> mode 3
//      otherwise                 -> mode 0
//  - ly>=VISIBLE_LINES -> mode 1 for the whole line.
//  - mode/ly/dot are mutually consistent in every cycle; they share one state register set.
//  - drawline=1 exactly in the cycle with ly<VISIBLE_LINES and dot==OAM_DOTS+XFER_DOTS (first HBlank dot).
//    One pulse per visible line, 144 per frame. ly in that cycle is the line to render.
//  - vblank_irq=1 exactly in the cycle with ly==VISIBLE_LINES, dot==0. One per frame.
//  - frame_start=1 exactly in the cycle with ly==0, dot==0 while enabled.
//  - lyc_match = (ly==lyc) compared on the current cycle's ly and lyc; no lag vs ly.
//  - Timing: frame = DOTS_PER_LINE*TOTAL_LINES cycles (70224 default).
//    drawline period = DOTS_PER_LINE (456).
//  - Simultaneous events: lcd_en falling in the same cycle a strobe would fire suppresses the strobe.
//    reset overrides lcd_en.
//  - Arithmetic: dot is a 9-bit unsigned counter and ly an 8-bit unsigned counter; no saturation, wrap only as above.
// CONFIGURATION
//  LCD_TIMING_STAT_IRQ_EN defined:
//    - stat_line = OR of enabled sources:
//        stat_sel[0] & mode==0
//        stat_sel[1] & mode==1
//        stat_sel[2] & mode==2
//        stat_sel[3] & lyc_match
//    - stat_irq = 1-cycle pulse on each 0->1 edge of stat_line (STAT blocking: overlapping sources give one pulse).
//    - stat_line history resets to 0 on reset and while lcd_en==0.
//  LCD_TIMING_STAT_IRQ_EN undefined:
//    - stat_irq tied to 0; stat_sel ignored.
//    - No edge-detect logic is built. All other behaviour is unchanged.
// TESTING
//  1 Hold reset=0 for 5 clk with lcd_en=1 -> all outputs 0.
//    Release -> first cycle dot0/ly0/mode2, frame_start=1.
//  2 Run one full frame -> 144 drawline pulses, each 456 cycles apart:
//    - first at cycle 252 with ly=0; last with ly=143.
//    - vblank_irq once at cycle 65664.
//    - frame_start again at cycle 70224.
//  3 Per-line mode check, line 5:
//    - mode 2 for dots 0-79, mode 3 for dots 80-251, mode 0 for dots 252-455.
//    - line 150 mode 1 throughout.
//  4 lyc=10 -> lyc_match high exactly during the 456 cycles of ly=10.
//    With STAT_IRQ_EN and stat_sel=4'b1000 -> one stat_irq at ly=10, dot 0.
//  5 With STAT_IRQ_EN, stat_sel=4'b0011 (HBlank+VBlank):
//    - one stat_irq at line 143 dot 252.
//    - no second pulse at line 144 dot 0 (line stays high).
//  6 Drop lcd_en at ly=50 dot 252 -> no drawline that cycle, outputs idle.
//    Re-raise 100 cycles later -> ly0/dot0/mode2, frame_start=1.

Source files
------------

// File: rtl/lcd_timing_ctrl_if.sv
// rtl/lcd_timing_ctrl_if.sv - register inputs and timing outputs of the LCD timing generator
interface lcd_timing_ctrl_if;
   logic       lcd_en;
   logic [7:0] lyc;
   logic [3:0] stat_sel;
   logic       drawline;
   logic [1:0] mode;
   logic [7:0] ly;
   logic       lyc_match;
   logic       vblank_irq;
   logic       stat_irq;
   logic       frame_start;

   // master: the timing generator itself
   modport master (
      input  lcd_en, lyc, stat_sel,
      output drawline, mode, ly, lyc_match, vblank_irq, stat_irq, frame_start
   );

   // slave: register file / renderer side
   modport slave (
      output lcd_en, lyc, stat_sel,
      input  drawline, mode, ly, lyc_match, vblank_irq, stat_irq, frame_start
   );
endinterface

// File: rtl/lcd_timing_ctrl.sv
// rtl/lcd_timing_ctrl.sv - LCD dot/line timing generator; STAT interrupt built only with LCD_TIMING_STAT_IRQ_EN
module lcd_timing_ctrl #(
   parameter int DOTS_PER_LINE = 456,
   parameter int OAM_DOTS      = 80,
   parameter int XFER_DOTS     = 172,
   parameter int VISIBLE_LINES = 144,
   parameter int TOTAL_LINES   = 154
) (
   input  logic             clk,
   input  logic             reset,
   lcd_timing_ctrl_if.master bus
);
   localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
   localparam logic [8:0] XFER_END  = 9'(OAM_DOTS + XFER_DOTS);
   localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
   localparam logic [7:0] VIS_LINES = 8'(VISIBLE_LINES);
   localparam logic [7:0] LAST_LINE = 8'(TOTAL_LINES - 1);

   // counter state; run marks that the previous cycle was already enabled
   logic [8:0] dot_q, dot_nxt;
   logic [7:0] ly_q, ly_nxt;
   logic       run_q, run_nxt;

   // outputs decoded from the next counter values so they register together with them
   logic [1:0] mode_nxt;
   logic       drawline_nxt;
   logic       vblank_nxt;
   logic       frame_nxt;
   logic       match_nxt;

   // state register: dot/ly/run, cleared by reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         dot_q <= 9'd0;
         ly_q  <= 8'd0;
         run_q <= 1'b0;
      end else begin
         dot_q <= dot_nxt;
         ly_q  <= ly_nxt;
         run_q <= run_nxt;
      end
   end

   // next-state: first enabled cycle starts at dot0/line0, then dots and lines wrap
   always_comb begin
      run_nxt = bus.lcd_en;
      dot_nxt = 9'd0;
      ly_nxt  = 8'd0;
      if (bus.lcd_en && run_q) begin
         if (dot_q == LAST_DOT) begin
            dot_nxt = 9'd0;
            ly_nxt  = (ly_q == LAST_LINE) ? 8'd0 : ly_q + 8'd1;
         end else begin
            dot_nxt = dot_q + 9'd1;
            ly_nxt  = ly_q;
         end
      end
   end

   // output decode of the next state; a disabled cycle decodes to idle so strobes are suppressed
   always_comb begin
      mode_nxt     = 2'd0;
      drawline_nxt = 1'b0;
      vblank_nxt   = 1'b0;
      frame_nxt    = 1'b0;
      match_nxt    = (ly_nxt == bus.lyc);
      if (bus.lcd_en) begin
         if (ly_nxt >= VIS_LINES)     mode_nxt = 2'd1;
         else if (dot_nxt < OAM_END)  mode_nxt = 2'd2;
         else if (dot_nxt < XFER_END) mode_nxt = 2'd3;
         else                         mode_nxt = 2'd0;
         drawline_nxt = (ly_nxt < VIS_LINES) && (dot_nxt == XFER_END);
         vblank_nxt   = (ly_nxt == VIS_LINES) && (dot_nxt == 9'd0);
         frame_nxt    = (ly_nxt == 8'd0) && (dot_nxt == 9'd0);
      end
   end

   assign bus.ly = ly_q;

   // output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.mode        <= 2'd0;
         bus.drawline    <= 1'b0;
         bus.vblank_irq  <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.lyc_match   <= 1'b0;
      end else begin
         bus.mode        <= mode_nxt;
         bus.drawline    <= drawline_nxt;
         bus.vblank_irq  <= vblank_nxt;
         bus.frame_start <= frame_nxt;
         bus.lyc_match   <= match_nxt;
      end
   end

`ifdef LCD_TIMING_STAT_IRQ_EN
   logic stat_line_nxt;
   logic stat_line_q;

   // STAT line: OR of enabled sources, forced low while disabled
   always_comb begin
      stat_line_nxt = bus.lcd_en &&
                      ((bus.stat_sel[0] && (mode_nxt == 2'd0)) ||
                       (bus.stat_sel[1] && (mode_nxt == 2'd1)) ||
                       (bus.stat_sel[2] && (mode_nxt == 2'd2)) ||
                       (bus.stat_sel[3] && match_nxt));
   end

   // rising-edge detect: overlapping sources keep the line high and give one pulse
   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_line_q  <= 1'b0;
         bus.stat_irq <= 1'b0;
      end else begin
         stat_line_q  <= stat_line_nxt;
         bus.stat_irq <= stat_line_nxt && !stat_line_q;
      end
   end
`else
   logic unused_stat_sel;
   assign unused_stat_sel = ^bus.stat_sel;
   assign bus.stat_irq    = 1'b0;
`endif
endmodule
